multicycle_ctrl: RTL

//  Multi-cycle sequencer for the RV32I subset datapath (R, I-ALU, LOAD, STORE, BRANCH).

---
 rtl/rv_ctrl_pkg.sv | 42 ++++
 rtl/mem_wait_timer.sv | 40 ++++
 rtl/multicycle_ctrl.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/rv_ctrl_pkg.sv
// rtl/rv_ctrl_pkg.sv - shared opcodes, FSM states and datapath select codes for the multi-cycle controller
package rv_ctrl_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC_R,
        S_EXEC_I,
        S_ADDR,
        S_MEM_RD,
        S_MEM_WR,
        S_ALU_WB,
        S_LOAD_WB,
        S_BRANCH
    } state_e;

    localparam logic [1:0] SRC_A_PC     = 2'b00;
    localparam logic [1:0] SRC_A_RS1    = 2'b01;
    localparam logic [1:0] SRC_A_OLD_PC = 2'b10;

    localparam logic [1:0] SRC_B_RS2    = 2'b00;
    localparam logic [1:0] SRC_B_FOUR   = 2'b01;
    localparam logic [1:0] SRC_B_IMM    = 2'b10;

    localparam logic [1:0] ALUOP_ADD    = 2'b00;
    localparam logic [1:0] ALUOP_SUB    = 2'b01;
    localparam logic [1:0] ALUOP_R_FN   = 2'b10;
    localparam logic [1:0] ALUOP_I_FN   = 2'b11;

    // States that own the memory port and therefore run the wait timer.
    function automatic logic is_mem_state(input state_e s);
        return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// rtl/mem_wait_timer.sv - per-access wait-cycle counter with expiry flag
// Ports:
//   clk, rstn  clock, asynchronous active-low reset
//   clear_i    restart the count at zero (new access or not accessing)
//   count_i    a cycle passed without mem_ready
//   expired_o  count has reached TIMEOUT (never set when TIMEOUT = 0)
module mem_wait_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rstn,
    input  logic clear_i,
    input  logic count_i,
    output logic expired_o
);

    localparam int W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    logic [W-1:0] cnt_q, cnt_d;

    assign expired_o = (TIMEOUT != 0) && (cnt_q == W'(TIMEOUT));

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (count_i && !expired_o && (TIMEOUT != 0)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multi-cycle RV32I-subset sequencer with memory handshake and instret
// Ports:
//   clk, rstn            clock, asynchronous active-low reset
//   halt                 park in IDLE at the next instruction boundary
//   opcode               IR[6:0], valid from DECODE onward
//   mem_ready            memory finishes the current access this cycle
//   mem_req/mem_we/iord  memory request, write, address select (0 PC, 1 ALUOut)
//   ir_write, mdr_write  latch IR/old_pc, latch load data
//   pc_write(_cond)      PC update unconditional / on ALU zero; pc_src selects source
//   alu_src_a/b, aluop   ALU operand and operation selects
//   mem_to_reg, reg_write  writeback select and enable
//   illegal, bus_err     one-cycle pulses: bad opcode, access timeout
//   instret              retired instruction count, wraps
module multicycle_ctrl
    import rv_ctrl_pkg::*;
#(
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             halt,
    input  logic [6:0]       opcode,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             iord,
    output logic             ir_write,
    output logic             mdr_write,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic             pc_src,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       aluop,
    output logic             mem_to_reg,
    output logic             reg_write,
    output logic             illegal,
    output logic             bus_err,
    output logic [CNT_W-1:0] instret
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] instret_q, instret_d;
    logic             retire;
    logic             expired;
    logic             tmr_clear;

    // Clearing on any state change gives each access a fresh count, including
    // a FETCH that directly follows a completed store.
    assign tmr_clear = (state_d != state_q) || !is_mem_state(state_q);

    mem_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk       (clk),
        .rstn      (rstn),
        .clear_i   (tmr_clear),
        .count_i   (!mem_ready),
        .expired_o (expired)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= S_IDLE;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            instret_q <= instret_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        retire        = 1'b0;
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        iord          = 1'b0;
        ir_write      = 1'b0;
        mdr_write     = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_src        = 1'b0;
        alu_src_a     = SRC_A_PC;
        alu_src_b     = SRC_B_RS2;
        aluop         = ALUOP_ADD;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        illegal       = 1'b0;
        bus_err       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!halt) state_d = S_FETCH;
            end
            S_FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = SRC_B_FOUR;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = S_DECODE;
                end else if (expired) begin
                    // PC was not advanced, so the next FETCH repeats this address.
                    bus_err = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_DECODE: begin
                // Branch target = old_pc + imm, parked in ALUOut for BRANCH.
                alu_src_a = SRC_A_OLD_PC;
                alu_src_b = SRC_B_IMM;
                case (opcode)
                    OP_R:               state_d = S_EXEC_R;
                    OP_I:               state_d = S_EXEC_I;
                    OP_LOAD, OP_STORE:  state_d = S_ADDR;
                    OP_BRANCH:          state_d = S_BRANCH;
                    default: begin
                        illegal = 1'b1;
                        state_d = halt ? S_IDLE : S_FETCH;
                    end
                endcase
            end
            S_EXEC_R: begin
                alu_src_a = SRC_A_RS1;
                aluop     = ALUOP_R_FN;
                state_d   = S_ALU_WB;
            end
            S_EXEC_I: begin
                alu_src_a = SRC_A_RS1;
                alu_src_b = SRC_B_IMM;
                aluop     = ALUOP_I_FN;
                state_d   = S_ALU_WB;
            end
            S_ADDR: begin
                alu_src_a = SRC_A_RS1;
                alu_src_b = SRC_B_IMM;
                state_d   = (opcode == OP_STORE) ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                if (mem_ready) begin
                    mdr_write = 1'b1;
                    state_d   = S_LOAD_WB;
                end else if (expired) begin
                    bus_err = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_MEM_WR: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                mem_we  = 1'b1;
                if (mem_ready) begin
                    retire = 1'b1;
                end else if (expired) begin
                    bus_err = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_ALU_WB: begin
                reg_write = 1'b1;
                retire    = 1'b1;
            end
            S_LOAD_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                retire     = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a     = SRC_A_RS1;
                aluop         = ALUOP_SUB;
                pc_write_cond = 1'b1;
                pc_src        = 1'b1;
                retire        = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        // Every retiring state ends at an instruction boundary, where halt is honoured.
        if (retire) state_d = halt ? S_IDLE : S_FETCH;
    end

    assign instret_d = retire ? instret_q + CNT_W'(1) : instret_q;
    assign instret   = instret_q;

endmodule
